// File: rtl/cpu_pkg.sv
// Shared constants and next-PC select encoding for the pipelined MIPS core.
package cpu_pkg;

  localparam logic [31:0] RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] ILLOP     = 32'h8000_0004;
  localparam logic [31:0] XADR      = 32'h8000_0008;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // PCS_HOLD covers the stall case, where neither PC nor IF/ID moves.
  typedef enum logic [2:0] {
    PCS_SEQ,
    PCS_BR,
    PCS_J,
    PCS_JR,
    PCS_IRQ,
    PCS_EXC,
    PCS_HOLD
  } pc_sel_e;

  // Kernel bit is sticky; the low 31 bits wrap.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority encoder: chooses the PC source and computes the next PC and PC+4.
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter logic [31:0] IRQ_VEC = ILLOP,
  parameter logic [31:0] EXC_VEC = XADR
) (
  input  logic [31:0] pc,
  input  logic [3:0]  id_pc_plus4_hi,
  input  logic [25:0] id_instr_index,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        except_id,
  input  logic        irq_take,
  output pc_sel_e     sel,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4
);

  always_comb begin
    pc_plus4 = pc_inc(pc);
    sel      = PCS_SEQ;
    next_pc  = pc_plus4;
    // An EX-stage branch outranks stall: the stalled ID instruction is wrong-path.
    if (branch_taken) begin
      sel     = PCS_BR;
      next_pc = branch_target;
    end else if (stall) begin
      sel     = PCS_HOLD;
      next_pc = pc;
    end else if (except_id) begin
      sel     = PCS_EXC;
      next_pc = EXC_VEC;
    end else if (jr) begin
      sel     = PCS_JR;
      next_pc = jr_target;
    end else if (jump) begin
      sel     = PCS_J;
      next_pc = {id_pc_plus4_hi, id_instr_index, 2'b00};
    end else if (irq_take) begin
      sel     = PCS_IRQ;
      next_pc = IRQ_VEC;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Define IRQ_SYNC_EN to pass irq_req through a 2-flop synchronizer.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
  parameter logic [31:0] ILLOP     = cpu_pkg::ILLOP,
  parameter logic [31:0] XADR      = cpu_pkg::XADR,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        except_id,
  input  logic        irq_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_irq,
  output logic        if_id_valid
);

  import cpu_pkg::*;

  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc_plus4_q;
  logic        irq_q;
  logic        valid_q;

  logic        irq_level;
  logic        irq_take;
  pc_sel_e     sel;
  logic [31:0] next_pc;
  logic [31:0] pc_plus4;

`ifdef IRQ_SYNC_EN
  logic [1:0] irq_sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_sync_q <= 2'b00;
    end else begin
      irq_sync_q <= {irq_sync_q[0], irq_req};
    end
  end

  assign irq_level = irq_sync_q[1];
`else
  assign irq_level = irq_req;
`endif

  // Kernel mode masks interrupts, so the handler at ILLOP cannot re-enter.
  assign irq_take = irq_level & ~pc_q[31];

  pc_next_sel #(
    .IRQ_VEC (ILLOP),
    .EXC_VEC (XADR)
  ) u_pc_next_sel (
    .pc             (pc_q),
    .id_pc_plus4_hi (pc_plus4_q[31:28]),
    .id_instr_index (instr_q[25:0]),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .jr             (jr),
    .jr_target      (jr_target),
    .except_id      (except_id),
    .irq_take       (irq_take),
    .sel            (sel),
    .next_pc        (next_pc),
    .pc_plus4       (pc_plus4)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'h0;
      irq_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      pc_q <= next_pc;
      case (sel)
        PCS_HOLD: ;
        PCS_SEQ: begin
          instr_q    <= imem_data;
          pc_plus4_q <= pc_plus4;
          irq_q      <= 1'b0;
          valid_q    <= 1'b1;
        end
        // Replaced instruction's own address becomes the return point.
        PCS_IRQ: begin
          instr_q    <= NOP_INSTR;
          pc_plus4_q <= pc_q;
          irq_q      <= 1'b1;
          valid_q    <= 1'b1;
        end
        default: begin
          instr_q    <= NOP_INSTR;
          pc_plus4_q <= 32'h0;
          irq_q      <= 1'b0;
          valid_q    <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc_plus4_q;
  assign if_id_irq      = irq_q;
  assign if_id_valid    = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios then randomized redirects.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump, jr, except_id, irq_req;
  logic [31:0] branch_target, jr_target, imem_addr, imem_data;
  logic [31:0] if_id_instr, if_id_pc_plus4;
  logic        if_id_irq, if_id_valid;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        irq;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: architectural PC and IF/ID contents.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_irq, m_valid, m_s1, m_s2;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0040_000C) return 32'h0810_0000;  // j with index 26'h010_0000
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] inc(input logic [31:0] a);
    return (a & 32'h8000_0000) | ((a + 32'd4) & 32'h7FFF_FFFF);
  endfunction

  assign imem_data = mem(imem_addr);

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .jr             (jr),
    .jr_target      (jr_target),
    .except_id      (except_id),
    .irq_req        (irq_req),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_irq      (if_id_irq),
    .if_id_valid    (if_id_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  task automatic bubble();
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_irq   = 1'b0;
    m_valid = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, queue the expectation, move to next negedge.
  task automatic step(input logic rst, input logic st, input logic br, input logic [31:0] bt,
                      input logic jp, input logic jrr, input logic [31:0] jt,
                      input logic exc, input logic irq);
    logic irq_eff;
    reset = rst; stall = st; branch_taken = br; branch_target = bt;
    jump = jp; jr = jrr; jr_target = jt; except_id = exc; irq_req = irq;
`ifdef IRQ_SYNC_EN
    irq_eff = m_s2;
`else
    irq_eff = irq;
`endif
    if (!rst) begin
      m_pc = 32'h8000_0000;
      bubble();
      m_s1 = 1'b0;
      m_s2 = 1'b0;
    end else begin
      m_s2 = m_s1;
      m_s1 = irq;
      if (br) begin
        m_pc = bt;
        bubble();
      end else if (st) begin
        // hold
      end else if (exc) begin
        m_pc = 32'h8000_0008;
        bubble();
      end else if (jrr) begin
        m_pc = jt;
        bubble();
      end else if (jp) begin
        m_pc = {m_pc4[31:28], m_instr[25:0], 2'b00};
        bubble();
      end else if (irq_eff && m_pc < 32'h8000_0000) begin
        m_pc4   = m_pc;
        m_instr = 32'h0;
        m_irq   = 1'b1;
        m_valid = 1'b1;
        m_pc    = 32'h8000_0004;
      end else begin
        m_instr = mem(m_pc);
        m_pc4   = inc(m_pc);
        m_irq   = 1'b0;
        m_valid = 1'b1;
        m_pc    = m_pc4;
      end
    end
    exp_q.push_back('{pc: m_pc, instr: m_instr, pc4: m_pc4, irq: m_irq, valid: m_valid});
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic branch_to(input logic [31:0] t);
    step(1'b1, 1'b0, 1'b1, t, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Monitor: compares every registered output once per cycle against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_imem_addr", imem_addr, e.pc);
        chk("sb_instr", if_id_instr, e.instr);
        chk("sb_pc_plus4", if_id_pc_plus4, e.pc4);
        chk("sb_irq", {31'b0, if_id_irq}, {31'b0, e.irq});
        chk("sb_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
      end
    end
  end

  initial begin
    logic [31:0] bt, jt;
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    jump = 1'b0; jr = 1'b0; jr_target = 32'h0; except_id = 1'b0; irq_req = 1'b0;
    @(negedge clk);

    // Reset and sequential fetch from the reset vector
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h1234, 1'b1, 1'b1, 32'h0, 1'b1, 1'b1);
    chk("rst_pc", imem_addr, 32'h8000_0000);
    chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
    chk("rst_pc4", if_id_pc_plus4, 32'h0);
    idle();
    chk("seq1_pc", imem_addr, 32'h8000_0004);
    chk("seq1_valid", {31'b0, if_id_valid}, 32'h1);
    chk("seq1_pc4", if_id_pc_plus4, 32'h8000_0004);
    idle();
    chk("seq2_pc", imem_addr, 32'h8000_0008);

    // Jump resolved in ID
    branch_to(32'h0040_000C);
    idle();
    chk("pre_jump_pc", imem_addr, 32'h0040_0010);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("jump_pc", imem_addr, 32'h0040_0000);
    chk("jump_valid", {31'b0, if_id_valid}, 32'h0);
    chk("jump_instr", if_id_instr, 32'h0);

    // Stall suppresses jr, then jr proceeds
    branch_to(32'h0040_001C);
    idle();
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_1000, 1'b0, 1'b0);
    chk("stall_pc", imem_addr, 32'h0040_0020);
    chk("stall_instr", if_id_instr, mem(32'h0040_001C));
    chk("stall_valid", {31'b0, if_id_valid}, 32'h1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_1000, 1'b0, 1'b0);
    chk("jr_pc", imem_addr, 32'h0040_1000);

    // Branch beats stall and exception
    step(1'b1, 1'b1, 1'b1, 32'h0040_0100, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("br_pc", imem_addr, 32'h0040_0100);
    chk("br_valid", {31'b0, if_id_valid}, 32'h0);

    // Interrupt from user mode, held request must not re-trigger
    branch_to(32'h0040_0040);
`ifdef IRQ_SYNC_EN
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("irq_sync_wait1", imem_addr, 32'h0040_0044);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("irq_sync_wait2", imem_addr, 32'h0040_0048);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("irq_pc", imem_addr, 32'h8000_0004);
    chk("irq_flag", {31'b0, if_id_irq}, 32'h1);
    chk("irq_pc4", if_id_pc_plus4, 32'h0040_0048);
`else
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("irq_pc", imem_addr, 32'h8000_0004);
    chk("irq_flag", {31'b0, if_id_irq}, 32'h1);
    chk("irq_pc4", if_id_pc_plus4, 32'h0040_0040);
    chk("irq_valid", {31'b0, if_id_valid}, 32'h1);
`endif
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("irq_masked_pc", imem_addr, 32'h8000_0008);
    chk("irq_masked_flag", {31'b0, if_id_irq}, 32'h0);

    // Exception from ID
    branch_to(32'h0040_0080);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("exc_pc", imem_addr, 32'h8000_0008);
    chk("exc_valid", {31'b0, if_id_valid}, 32'h0);

    // Randomized mix of redirects, stalls, interrupts and resets
    for (int i = 0; i < 600; i++) begin
      bt = $urandom;
      jt = $urandom;
      if ($urandom_range(3) != 0) bt[31] = 1'b0;
      if ($urandom_range(3) != 0) jt[31] = 1'b0;
      step(($urandom_range(39) != 0), ($urandom_range(4) == 0), ($urandom_range(5) == 0), bt,
           ($urandom_range(5) == 0), ($urandom_range(7) == 0), jt,
           ($urandom_range(9) == 0), ($urandom_range(3) == 0));
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the pipelined MIPS core; sits directly upstream of the ID-stage control decoder.
- Owns the PC and selects the next PC from: sequential, taken branch (EX), jump/jr (ID), exception (ID), interrupt vector.
- Drives instruction-memory address and presents instruction, PC+4 and IRQ flag to ID; inserts bubbles on flush and holds on stall.

Parameters:
- RESET_PC, 32'h8000_0000, PC after reset (kernel mode).
- ILLOP, 32'h8000_0004, interrupt vector.
- XADR, 32'h8000_0008, exception vector.
- NOP_INSTR, 32'h0000_0000, bubble instruction (sll $0,$0,0).

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  load-use hold from hazard unit.
- branch_taken  in  1  EX-stage branch resolved taken.
- branch_target  in  32  EX-stage branch target.
- jump  in  1  ID-stage j/jal (isJ==01).
- jr  in  1  ID-stage jr/jalr (isJ==10).
- jr_target  in  32  forwarded rs value for jr/jalr.
- except_id  in  1  ID-stage undefined-instruction exception.
- irq_req  in  1  external interrupt request, level.
- imem_addr  out  32  instruction-memory address (= PC).
- imem_data  in  32  instruction read, combinational from imem_addr.
- if_id_instr  out  32  instruction to ID.
- if_id_pc_plus4  out  32  return-address field to ID.
- if_id_irq  out  1  IRQ marker to ID decoder.
- if_id_valid  out  1  0 = bubble.

Behaviour:
- Reset (reset==0 at clk edge): PC<=RESET_PC; if_id_instr<=NOP_INSTR; if_id_pc_plus4<=0; if_id_irq<=0; if_id_valid<=0.
- PC+4 rule: pc_plus4 = {PC[31], PC[30:0]+31'd4}; bit 31 (kernel bit) preserved, bits [30:0] wrap modulo 2^31.
- Jump target: {if_id_pc_plus4[31:28], if_id_instr[25:0], 2'b00}.
- Next-PC priority per cycle, highest first:
  1. branch_taken: PC<=branch_target; IF/ID<=bubble (overrides stall; ID instruction is wrong-path).
  2. stall: PC and IF/ID hold; jump/jr/except_id/irq ignored this cycle.
  3. except_id: PC<=XADR; IF/ID<=bubble.
  4. jr: PC<=jr_target; IF/ID<=bubble.
  5. jump: PC<=jump target; IF/ID<=bubble.
  6. irq_take: PC<=ILLOP; IF/ID<={instr=NOP_INSTR, pc_plus4=PC (address of replaced instruction), irq=1, valid=1}.
  7. sequential: PC<=pc_plus4; IF/ID<={imem_data, pc_plus4, irq=0, valid=1}.
- irq_take = irq_req & ~PC[31]; interrupts masked in kernel mode, so no re-entry once PC=ILLOP.
- Bubble = {NOP_INSTR, pc_plus4 field 0, irq 0, valid 0}.
- Latency: imem_data to if_id_instr one cycle; redirect inputs affect imem_addr the next cycle; wrong-path penalty = 1 bubble (ID redirect) or 2 (EX branch, ID bubble generated by branch unit upstream of EX).
- Reset asserted mid-stall or mid-redirect: reset wins unconditionally.
- All outputs registered except imem_addr (= PC register).

Optional Feature:
- IRQ_SYNC_EN defined: irq_req passes through a 2-flop synchronizer (reset to 0) before irq_take; adds 2 cycles of IRQ latency.
- Undefined: irq_req used directly (assumed synchronous to clk).

Decomposition:
- Shared package cpu_pkg: RESET_PC/ILLOP/XADR constants, NOP_INSTR, next-PC select enum (PCS_SEQ, PCS_BR, PCS_J, PCS_JR, PCS_IRQ, PCS_EXC).
- One sub-module: pc_next_sel (combinational priority encoder producing select enum + next PC); registers stay in fetch_stage.

Test Plan:
- Reset release -> imem_addr=32'h8000_0000, then 8000_0004, 8000_0008 on successive cycles; first if_id_valid=1 one cycle after release.
- PC=32'h0040_0010, jump with if_id_instr[25:0]=26'h010_0000 -> next PC=32'h0040_0000, IF/ID bubble (valid=0, instr=0).
- stall=1 and jr=1 same cycle at PC=32'h0040_0020 -> PC and IF/ID unchanged; release stall, jr_target=32'h0040_1000 -> PC=32'h0040_1000.
- branch_taken=1 (target 32'h0040_0100) with stall=1 and except_id=1 -> PC=32'h0040_0100, IF/ID bubble.
- irq_req=1 at PC=32'h0040_0040 -> PC=32'h8000_0004, if_id_irq=1, if_id_pc_plus4=32'h0040_0040; irq_req held -> no second IRQ while PC[31]=1.
- except_id=1 at PC=32'h0040_0080 -> PC=32'h8000_0008, IF/ID bubble; with IRQ_SYNC_EN, IRQ asserted at cycle n taken at cycle n+2.
